// File: rtl/trim_write_sequencer_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// trim_write_sequencer_if : valid/ready + done write channel to the SPI master
// Revision 1.0
// ---------------------------------------------------------------------------
interface trim_write_sequencer_if;
  logic       spi_valid;
  logic       spi_ready;
  logic [7:0] spi_addr;
  logic [7:0] spi_wdata;
  logic       spi_done;

  modport master (
    output spi_valid,
    output spi_addr,
    output spi_wdata,
    input  spi_ready,
    input  spi_done
  );

  modport slave (
    input  spi_valid,
    input  spi_addr,
    input  spi_wdata,
    output spi_ready,
    output spi_done
  );
endinterface
`default_nettype wire

// File: rtl/trim_write_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// trim_write_sequencer : seven ordered trim-register writes with gap/timeout
// Revision 1.0
// ---------------------------------------------------------------------------
module trim_write_sequencer #(
  parameter logic [7:0]  MBIT_CALIB     = 8'h2C,
  parameter logic [7:0]  BIAS_CALIB     = 8'h05,
  parameter logic [7:0]  CLK_CALIB      = 8'h15,
  parameter logic [7:0]  BPA_CALIB      = 8'h0C,
  parameter logic [7:0]  PU_CALIB       = 8'h88,
  parameter int unsigned GAP_CYCLES     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    err_o,
  output logic [2:0]              write_count_o,
  trim_write_sequencer_if.master  spi
);

  localparam int unsigned      TMO_W    = $clog2(TIMEOUT_CYCLES);
  localparam int unsigned      GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [2:0]       LAST_IDX = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_REQ       = 3'd1,
    S_WAIT_DONE = 3'd2,
    S_GAP       = 3'd3,
    S_FINISH    = 3'd4
  } state_e;

  state_e           state_q;
  logic [2:0]       idx_q;
  logic [2:0]       wcnt_q;
  logic [TMO_W-1:0] tmo_q;
  logic [GAP_W-1:0] gap_q;
  logic             busy_q;
  logic             done_q;
  logic             err_q;
  logic             valid_q;
  logic [7:0]       addr_q;
  logic [7:0]       wdata_q;
  logic [2:0]       idx_d;

  // {address, value} of each write in issue order
  function automatic logic [15:0] entry(input logic [2:0] i);
    logic [15:0] e;
    e = {8'h09, PU_CALIB};
    case (i)
      3'd0:    e = {8'h03, MBIT_CALIB};
      3'd1:    e = {8'h04, BIAS_CALIB};
      3'd2:    e = {8'h05, BIAS_CALIB};
      3'd3:    e = {8'h06, CLK_CALIB};
      3'd4:    e = {8'h07, BPA_CALIB};
      3'd5:    e = {8'h08, BPA_CALIB};
      default: e = {8'h09, PU_CALIB};
    endcase
    return e;
  endfunction

  assign idx_d = idx_q + 3'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= 3'd0;
      wcnt_q  <= 3'd0;
      tmo_q   <= '0;
      gap_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      addr_q  <= 8'h00;
      wdata_q <= 8'h00;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            state_q            <= S_REQ;
            idx_q              <= 3'd0;
            wcnt_q             <= 3'd0;
            err_q              <= 1'b0;
            tmo_q              <= '0;
            busy_q             <= 1'b1;
            valid_q            <= 1'b1;
            {addr_q, wdata_q}  <= entry(3'd0);
          end
        end
        S_REQ: begin
          // An accept on the timeout edge still counts as an accept
          if (spi.spi_ready) begin
            state_q <= S_WAIT_DONE;
            valid_q <= 1'b0;
            tmo_q   <= tmo_q + 1'b1;
          end else if (tmo_q == TMO_LAST) begin
            state_q <= S_FINISH;
            valid_q <= 1'b0;
            err_q   <= 1'b1;
            done_q  <= 1'b1;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        S_WAIT_DONE: begin
          if (spi.spi_done) begin
            wcnt_q <= wcnt_q + 3'd1;
            if (idx_q == LAST_IDX) begin
              state_q <= S_FINISH;
              done_q  <= 1'b1;
            end else if (GAP_CYCLES > 0) begin
              state_q <= S_GAP;
              gap_q   <= '0;
            end else begin
              state_q           <= S_REQ;
              idx_q             <= idx_d;
              tmo_q             <= '0;
              valid_q           <= 1'b1;
              {addr_q, wdata_q} <= entry(idx_d);
            end
          end else if (tmo_q == TMO_LAST) begin
            state_q <= S_FINISH;
            err_q   <= 1'b1;
            done_q  <= 1'b1;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        S_GAP: begin
          if (gap_q == GAP_LAST) begin
            state_q           <= S_REQ;
            idx_q             <= idx_d;
            tmo_q             <= '0;
            valid_q           <= 1'b1;
            {addr_q, wdata_q} <= entry(idx_d);
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end
        S_FINISH: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign err_o         = err_q;
  assign write_count_o = wcnt_q;
  assign spi.spi_valid = valid_q;
  assign spi.spi_addr  = addr_q;
  assign spi.spi_wdata = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_trim_write_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_trim_write_sequencer : table, hand-written and random runs of the sequencer
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_trim_write_sequencer;

  localparam int GAP = 16;
  localparam int TMO = 1024;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    int         stall;
    int         lat;
  } vec_t;

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b0;
  logic       start   = 1'b0;
  logic       start_b = 1'b0;
  logic       busy, done, err;
  logic [2:0] wcnt;
  logic       busy_b, done_b, err_b;
  logic [2:0] wcnt_b;
  logic       b_acc   = 1'b0;

  int errs      = 0;
  int checks    = 0;
  int cyc       = 0;
  int done_cnt  = 0;
  int b_acc_cnt = 0;

  vec_t tbl[7];

  trim_write_sequencer_if ifa ();
  trim_write_sequencer_if ifb ();

  trim_write_sequencer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start_i       (start),
    .busy_o        (busy),
    .done_o        (done),
    .err_o         (err),
    .write_count_o (wcnt),
    .spi           (ifa)
  );

  trim_write_sequencer #(.GAP_CYCLES(0)) dut_nogap (
    .clk           (clk),
    .rst_n         (rst_n),
    .start_i       (start_b),
    .busy_o        (busy_b),
    .done_o        (done_b),
    .err_o         (err_b),
    .write_count_o (wcnt_b),
    .spi           (ifb)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  // Zero-gap instance: ready always high, done one cycle after each accept
  always @(negedge clk) begin
    b_acc        <= ifb.spi_valid & ifb.spi_ready;
    ifb.spi_done <= b_acc;
    if (ifb.spi_valid && ifb.spi_ready) b_acc_cnt <= b_acc_cnt + 1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: addresses run 0x03..0x09; values follow the trim-name order
  function automatic logic [7:0] model_addr(input int i);
    return 8'(3 + i);
  endfunction

  function automatic logic [7:0] model_data(input int i);
    case (i)
      0:       return 8'h2C;
      1, 2:    return 8'h05;
      3:       return 8'h15;
      4, 5:    return 8'h0C;
      default: return 8'h88;
    endcase
  endfunction

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_valid", ifa.spi_valid, 1);
    chk("start_err_clr", err, 0);
    chk("start_wcnt", wcnt, 0);
  endtask

  // Entered on a falling edge before write i is requested; returns one cycle
  // after spi_done (lat>0) or one cycle after the accept (lat==0).
  task automatic do_write(input int i, input int stall, input int lat, input int exp_gap,
                          input bit spur, input logic [7:0] exp_a, input logic [7:0] exp_d,
                          output int v_cyc);
    int gap;
    logic [7:0] a0, d0;
    ifa.spi_ready = (stall == 0);
    gap = 0;
    while (!ifa.spi_valid && gap < 300) begin
      ifa.spi_done = spur && (gap == 2);
      start        = spur && (gap == 4);
      @(negedge clk);
      gap++;
      if (spur && gap == 6) chk("spur_wcnt", wcnt, i);
    end
    ifa.spi_done = 1'b0;
    start        = 1'b0;
    chk("gap", gap, exp_gap);
    v_cyc = cyc;
    chk("addr", ifa.spi_addr, exp_a);
    chk("data", ifa.spi_wdata, exp_d);
    a0 = ifa.spi_addr;
    d0 = ifa.spi_wdata;
    for (int s = 1; s < stall; s++) begin
      @(negedge clk);
      chk("stall_hold", {ifa.spi_valid, ifa.spi_addr, ifa.spi_wdata}, {1'b1, a0, d0});
    end
    ifa.spi_ready = 1'b1;
    @(negedge clk);
    chk("accept_drop", ifa.spi_valid, 0);
    if (lat > 0) begin
      repeat (lat - 1) @(negedge clk);
      ifa.spi_done = 1'b1;
      @(negedge clk);
      ifa.spi_done = 1'b0;
      chk("wcnt", wcnt, i + 1);
    end
  endtask

  // kind 0: table nominal, 1: table with backpressure, 2: random
  task automatic run_seq(input int kind);
    int v, dc, st, lt;
    bit sp;
    dc = done_cnt;
    pulse_start();
    for (int i = 0; i < 7; i++) begin
      if (kind == 2) begin
        st = int'($urandom_range(0, 4));
        lt = int'($urandom_range(1, 5));
        sp = ($urandom_range(0, 1) == 1) && (i > 0);
        do_write(i, st, lt, (i == 0) ? 0 : GAP, sp, model_addr(i), model_data(i), v);
      end else begin
        do_write(i, (kind == 1) ? tbl[i].stall : 0, tbl[i].lat, (i == 0) ? 0 : GAP,
                 (kind == 0) && (i == 3), tbl[i].addr, tbl[i].data, v);
      end
    end
    chk("done_pulse", done, 1);
    chk("busy_finish", busy, 1);
    chk("wcnt_final", wcnt, 7);
    chk("err_final", err, 0);
    @(negedge clk);
    chk("done_low", done, 0);
    chk("busy_low", busy, 0);
    @(negedge clk);
    chk("one_done", done_cnt - dc, 1);
  endtask

  initial begin
    int v, n, dc, c0;
    bit vseen;
    ifa.spi_ready = 1'b1;
    ifa.spi_done  = 1'b0;
    ifb.spi_ready = 1'b1;
    tbl[0] = '{8'h03, 8'h2C, 0,  3};
    tbl[1] = '{8'h04, 8'h05, 0,  3};
    tbl[2] = '{8'h05, 8'h05, 10, 3};
    tbl[3] = '{8'h06, 8'h15, 0,  3};
    tbl[4] = '{8'h07, 8'h0C, 0,  3};
    tbl[5] = '{8'h08, 8'h0C, 0,  3};
    tbl[6] = '{8'h09, 8'h88, 0,  3};

    repeat (3) @(negedge clk);
    chk("reset_state", {busy, done, err, wcnt, ifa.spi_valid, ifa.spi_addr, ifa.spi_wdata}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_state", {busy, done, err, wcnt, ifa.spi_valid}, 0);

    run_seq(0);
    run_seq(1);

    // Timeout on the fourth write
    pulse_start();
    for (int i = 0; i < 3; i++) do_write(i, 0, 3, (i == 0) ? 0 : GAP, 1'b0, model_addr(i), model_data(i), v);
    do_write(3, 0, 0, GAP, 1'b0, 8'h06, 8'h15, v);
    n = 0;
    vseen = 1'b0;
    while (!done && n < TMO + 50) begin
      @(negedge clk);
      n++;
      if (ifa.spi_valid) vseen = 1'b1;
    end
    chk("tmo_latency", cyc - v, TMO);
    chk("tmo_err", err, 1);
    chk("tmo_wcnt", wcnt, 3);
    chk("tmo_no_valid", vseen, 0);
    @(negedge clk);
    chk("tmo_idle", busy, 0);
    repeat (5) @(negedge clk);
    chk("tmo_err_held", {err, ifa.spi_valid}, 2'b10);
    run_seq(0);

    // Zero-gap instance: minimum run length
    start_b = 1'b1;
    c0 = cyc;
    @(negedge clk);
    start_b = 1'b0;
    n = 0;
    while (!done_b && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("nogap_latency", cyc - c0, 15);
    chk("nogap_wcnt", wcnt_b, 7);
    chk("nogap_err", err_b, 0);
    repeat (3) @(negedge clk);
    chk("nogap_accepts", b_acc_cnt, 7);

    // Reset while waiting for the fifth write to finish
    pulse_start();
    for (int i = 0; i < 4; i++) do_write(i, 0, 2, (i == 0) ? 0 : GAP, 1'b0, model_addr(i), model_data(i), v);
    do_write(4, 0, 0, GAP, 1'b0, 8'h07, 8'h0C, v);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("async_reset", {busy, done, err, wcnt, ifa.spi_valid, ifa.spi_addr, ifa.spi_wdata}, 0);
    dc = done_cnt;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("reset_no_done", done_cnt - dc, 0);
    chk("reset_idle", busy, 0);

    for (int r = 0; r < 3; r++) run_seq(2);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/trim_write_sequencer.md
# trim_write_sequencer

Sequences the sensor trim-register programming step of the calibration path. On a single start request it issues seven ordered SPI write transactions (MBIT, BIAS top/bottom, CLK, BPA top/bottom, PU trim) to the SPI master through a valid/ready + done handshake. It inserts a programmable settle gap between writes and guards each transaction with a timeout. It sits between the calibration trigger logic and the shared SPI master, and reports busy/done/error to the top-level control.

## Interface
- MBIT_CALIB, 8'h2C, value written to MBIT trim register (0x03)
- BIAS_CALIB, 8'h05, value written to BIAS trim top (0x04) and bottom (0x05)
- CLK_CALIB, 8'h15, value written to CLK trim register (0x06)
- BPA_CALIB, 8'h0C, value written to BPA trim top (0x07) and bottom (0x08)
- PU_CALIB, 8'h88, value written to PU trim register (0x09)
- GAP_CYCLES, 16, idle cycles between consecutive writes (0 = no gap)
- TIMEOUT_CYCLES, 1024, max cycles per transaction from valid assertion to spi_done (≥ 2)

Ports:
- clk  in  1  system clock, all logic rising-edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to run the sequence
- busy  out  1  high while the sequence runs
- done  out  1  one-cycle pulse at sequence end (success or error)
- err  out  1  timeout flag, latched until next accepted start
- write_count  out  3  number of writes completed in current/last run (0–7)
- spi_valid  out  1  write request to SPI master
- spi_ready  in  1  SPI master accepts request when valid & ready
- spi_addr  out  8  trim register address, stable while spi_valid
- spi_wdata  out  8  trim value, stable while spi_valid
- spi_done  in  1  one-cycle pulse: accepted write finished on the bus

## Operation
- States: IDLE, REQ, WAIT_DONE, GAP, FINISH.
- Write table, index 0–6: (0x03,MBIT) (0x04,BIAS) (0x05,BIAS) (0x06,CLK) (0x07,BPA) (0x08,BPA) (0x09,PU).
- IDLE: start=1 → REQ, index=0, write_count=0, err=0.
- REQ: spi_valid=1, spi_addr/spi_wdata from table[index]. valid & ready → WAIT_DONE.
- WAIT_DONE: spi_valid=0. spi_done → write_count+1. If index=6, go FINISH. Else, if GAP_CYCLES>0, go GAP; if 0, go REQ with index+1.
- GAP: counts GAP_CYCLES cycles, then REQ with index+1.
- FINISH: done=1 for one cycle, then IDLE.
- Timeout counter: cleared on each REQ entry and counts in REQ and WAIT_DONE. When it reaches TIMEOUT_CYCLES, set err=1, drop spi_valid, go FINISH. Remaining writes are skipped.
- start while busy is ignored.
- spi_done outside WAIT_DONE is ignored, including in the accept cycle. spi_ready outside REQ is ignored.
- busy = (state != IDLE), including the FINISH cycle.

## Timing
- Reset values: busy=0, done=0, err=0, write_count=0, spi_valid=0, spi_addr=0, spi_wdata=0. State is IDLE.
- Reset mid-sequence aborts at once: spi_valid drops asynchronously and no done pulse is produced.
- start sampled at edge N → spi_valid=1 and busy=1 from cycle N+1.
- Accept at edge A → spi_valid=0 at A+1.
- spi_done at edge D → write_count updated at D+1. Next spi_valid at D+1+GAP_CYCLES.
- Last spi_done at edge D → done=1 in cycle D+1, busy=0 at D+2.
- Timeout: err and done assert together, TIMEOUT_CYCLES cycles after REQ entry. err stays high until the next accepted start.
- Minimum run with ready always high, done one cycle after accept, GAP_CYCLES=0: 7×2+1 cycles from start to done.

## Test plan
- Nominal run: start, ready held high, spi_done 3 cycles after each accept, GAP=16 → 7 writes in the order 0x03/2C, 0x04/05, 0x05/05, 0x06/15, 0x07/0C, 0x08/0C, 0x09/88. Exactly 16 idle cycles between writes. done pulses once, write_count=7, err=0.
- Backpressure: spi_ready held low 10 cycles on write 2 → spi_valid, addr 0x05 and data 0x05 stay stable throughout, then one accept only.
- Timeout: spi_done never returned on write 4 (addr 0x06) → err=1 and done pulse 1024 cycles after REQ entry. write_count=3, no further spi_valid. Next start clears err.
- start pulsed during busy and spurious spi_done during GAP → sequence and write_count unaffected.
- rst_n low during WAIT_DONE of write 5 → all outputs 0 immediately, no done pulse. A new start after release runs from 0x03.
- GAP_CYCLES=0, done one cycle after accept → done asserted 15 cycles after start.
